// File: rtl/hmac_req_arbiter.sv
// Round-robin arbiter sharing one HMAC-SHA256 core between NREQ requesters.
// Latches key/data, pulses go, waits for a fresh done edge, returns the result.
module hmac_req_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*512-1:0]   req_key_i,
  input  logic [NREQ*512-1:0]   req_data_i,
  output logic [NREQ-1:0]       rsp_valid_o,
  input  logic [NREQ-1:0]       rsp_ready_i,
  output logic [255:0]          rsp_hmac_o,
  output logic                  rsp_err_o,
  output logic                  core_go_o,
  output logic [511:0]          core_key_o,
  output logic [511:0]          core_data_o,
  input  logic [255:0]          core_hmac_i,
  input  logic                  core_done_i,
  output logic                  busy_o,
  output logic                  timeout_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WLOW,
    S_WHIGH,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [IW-1:0]       r_last;
  logic [IW-1:0]       r_gnt;
  logic [511:0]        r_key;
  logic [511:0]        r_data;
  logic [255:0]        r_hmac;
  logic                r_err;
  logic                r_timeout;
  logic [WW-1:0]       r_wdog;

  logic                w_found;
  logic [IW-1:0]       w_gidx;
  int                  w_idx;
  logic [NREQ-1:0]     w_sh;
  logic [NREQ*512-1:0] w_ksh;
  logic [NREQ*512-1:0] w_dsh;
  logic                w_expire;
  logic                w_rsp_rdy;

  // search upward from last+1, wrapping, so every requester gets a turn
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    w_sh    = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      w_sh = req_valid_i >> w_idx;
      if (!w_found && w_sh[0]) begin
        w_found = 1'b1;
        w_gidx  = w_idx[IW-1:0];
      end
    end
  end

  assign w_ksh     = req_key_i >> (512 * int'(w_gidx));
  assign w_dsh     = req_data_i >> (512 * int'(w_gidx));
  assign w_expire  = (r_wdog >= WW'(TIMEOUT - 1));
  assign w_rsp_rdy = |(rsp_ready_i & (ONE << r_gnt));

  always_comb begin
    w_next      = r_state;
    req_ready_o = '0;
    rsp_valid_o = '0;
    core_go_o   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          req_ready_o = ONE << w_gidx;
          w_next      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        core_go_o = 1'b1;
        w_next    = S_WLOW;
      end
      S_WLOW: begin
        if (w_expire)         w_next = S_RESP;
        else if (!core_done_i) w_next = S_WHIGH;
      end
      S_WHIGH: begin
        if (core_done_i || w_expire) w_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = ONE << r_gnt;
        if (w_rsp_rdy) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_last    <= IW'(NREQ - 1);
      r_gnt     <= '0;
      r_key     <= '0;
      r_data    <= '0;
      r_hmac    <= '0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_wdog    <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt  <= w_gidx;
            r_key  <= w_ksh[511:0];
            r_data <= w_dsh[511:0];
          end
        end
        S_LAUNCH: r_wdog <= '0;
        S_WLOW: begin
          r_wdog <= r_wdog + 1'b1;
          if (w_expire) begin
            r_hmac    <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        // completion beats expiry on the same cycle
        S_WHIGH: begin
          r_wdog <= r_wdog + 1'b1;
          if (core_done_i) begin
            r_hmac <= core_hmac_i;
            r_err  <= 1'b0;
          end else if (w_expire) begin
            r_hmac    <= '0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
          end
        end
        S_RESP: begin
          if (w_rsp_rdy) r_last <= r_gnt;
        end
        default: ;
      endcase
    end
  end

  assign rsp_hmac_o  = r_hmac;
  assign rsp_err_o   = r_err;
  assign core_key_o  = r_key;
  assign core_data_o = r_data;
  assign busy_o      = (r_state != S_IDLE);
  assign timeout_o   = r_timeout;

endmodule
